// File: rtl/fsk_pkg.sv
// fsk_pkg: shared FSK state encoding, byte width and half-period helper
package fsk_pkg;
  typedef enum logic {IDLE, TONE} state_t;
  localparam int BYTE_W = 8;
  function automatic int unsigned half_ticks(input int unsigned clock, input int unsigned freq);
    return clock / (2 * freq);
  endfunction
endpackage

// File: rtl/fsk_tone_generator_if.sv
// fsk_tone_generator_if: byte handshake, enable and tone/counter outputs of the FSK transmitter
interface fsk_tone_generator_if;
  import fsk_pkg::*;
  logic enable;
  logic [BYTE_W-1:0] data_in;
  logic data_valid;
  logic data_ready;
  logic sample_data;
  logic busy;
  logic [31:0] f1_value;
  logic [31:0] f2_value;
  modport master(output enable, data_in, data_valid, input data_ready, sample_data, busy, f1_value, f2_value);
  modport slave(input enable, data_in, data_valid, output data_ready, sample_data, busy, f1_value, f2_value);
endinterface

// File: rtl/fsk_half_period_timer.sv
// fsk_half_period_timer: counts cycles of a half-period and pulses toggle on its last cycle
module fsk_half_period_timer #(
  parameter int LW = 32,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          enable,
  input  logic          start,
  input  logic [LW-1:0] half_len,
  output logic          toggle,
  output logic [CW-1:0] half_count
);
  logic [LW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hc_q, hc_d;
  always_comb begin
    toggle = enable & (cnt_q == half_len - LW'(1));
    cnt_d = (start | toggle) ? '0 : enable ? cnt_q + LW'(1) : cnt_q;
    hc_d = start ? '0 : toggle ? hc_q + CW'(1) : hc_q;
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      cnt_q <= '0;
      hc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      hc_q <= hc_d;
    end
  end
  assign half_count = hc_q;
endmodule

// File: rtl/fsk_tone_generator.sv
// fsk_tone_generator: serialises bytes LSB-first as two-tone FSK with per-tone tick totals
module fsk_tone_generator
  import fsk_pkg::*;
#(
  parameter int unsigned FREQUENCY_1 = 9000,
  parameter int unsigned FREQUENCY_2 = 11000,
  parameter int unsigned CLOCK = 50000000,
  parameter int unsigned PERIODS_PER_BIT = 4
) (
  input logic clock,
  input logic clear,
  fsk_tone_generator_if.slave bus
);
  localparam int unsigned HALF1 = half_ticks(CLOCK, FREQUENCY_1);
  localparam int unsigned HALF2 = half_ticks(CLOCK, FREQUENCY_2);
  localparam int unsigned HPB = 2 * PERIODS_PER_BIT;
  localparam int CW = $clog2(HPB + 1);
  if (FREQUENCY_2 <= FREQUENCY_1 || HALF2 < 2 || PERIODS_PER_BIT < 1) begin : g_bad_params
    $error("fsk_tone_generator: invalid frequency or period parameters");
  end
  state_t state_q;
  logic [BYTE_W-1:0] shift_q;
  logic [2:0] bit_q;
  logic sample_q, busy_q;
  logic [31:0] f1_q, f2_q;
  logic hs, run, toggle, bit_done, last;
  logic [CW-1:0] half_count;
  assign bus.data_ready = (state_q == IDLE) & bus.enable & ~clear;
  assign hs = bus.data_valid & bus.data_ready;
  assign run = (state_q == TONE) & bus.enable;
  assign bit_done = toggle & (half_count == CW'(HPB - 1));
  assign last = bit_done & (bit_q == 3'd7);
  fsk_half_period_timer #(.LW(32), .CW(CW)) u_timer (
    .clock(clock),
    .clear(clear),
    .enable(run),
    .start(hs | bit_done),
    .half_len(shift_q[0] ? 32'(HALF2) : 32'(HALF1)),
    .toggle(toggle),
    .half_count(half_count)
  );
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q <= '0;
      sample_q <= 1'b0;
      busy_q <= 1'b0;
      f1_q <= '0;
      f2_q <= '0;
    end else if (hs) begin
      state_q <= TONE;
      shift_q <= bus.data_in;
      bit_q <= '0;
      sample_q <= 1'b1;
      busy_q <= 1'b1;
    end else if (run) begin
      if (shift_q[0]) f2_q <= f2_q + 32'd1;
      else f1_q <= f1_q + 32'd1;
      if (toggle) sample_q <= last ? 1'b0 : ~sample_q;
      if (bit_done) begin
        shift_q <= {1'b0, shift_q[BYTE_W-1:1]};
        bit_q <= bit_q + 3'd1;
      end
      if (last) begin
        state_q <= IDLE;
        busy_q <= 1'b0;
      end
    end
  end
  assign bus.sample_data = sample_q;
  assign bus.busy = busy_q;
  assign bus.f1_value = f1_q;
  assign bus.f2_value = f2_q;
endmodule
